// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_seq_debounce.sv
// Two-flop synchroniser for the pushbutton, with a stability filter when
// RESET_SEQ_DEBOUNCE_EN is defined. Output is the accepted level (1 = released).
module reset_seq_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_n,
  output logic dout_n
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = din_n;
    sync2_d = sync1_q;
  end

  // Sync flops come out of reset reading "pressed" so nothing releases early.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef RESET_SEQ_DEBOUNCE_EN
  localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);

  logic            db_q, db_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Counts consecutive cycles the synced level disagrees with the accepted one.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) db_d = sync2_q;
      else                                      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout_n = db_q;
`else
  // Filter not built; the parameter only keeps the interface uniform.
  if (DEBOUNCE_CYCLES < 1) begin : g_no_filter
  end

  assign dout_n = sync2_q;
`endif

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: waits for clean PLL locks and button, then releases
// NUM_STAGES domains in order. Optional button filter: RESET_SEQ_DEBOUNCE_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES     = 50_000,
  parameter int NUM_LOCKS       = 2,
  parameter int NUM_STAGES      = 3,
  parameter int STAGE_GAP       = 16,
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  btn_n,
  input  logic [NUM_LOCKS-1:0]  pll_locked,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  all_released,
  output logic [STATE_W-1:0]    state_o,
  output logic [7:0]            reset_count
);

  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int GAP_W  = cnt_w(STAGE_GAP);

  logic [NUM_LOCKS-1:0] lock_s1_q, lock_s1_d;
  logic [NUM_LOCKS-1:0] lock_s2_q, lock_s2_d;
  logic                 btn_ok;
  logic                 clean;

  reset_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clk),
    .reset_n (reset_n),
    .din_n   (btn_n),
    .dout_n  (btn_ok)
  );

  always_comb begin
    lock_s1_d = pll_locked;
    lock_s2_d = lock_s1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_s1_q <= '0;
      lock_s2_q <= '0;
    end else begin
      lock_s1_q <= lock_s1_d;
      lock_s2_q <= lock_s2_d;
    end
  end

  assign clean = btn_ok & (&lock_s2_q);

  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  all_rel_q, all_rel_d;
  logic [7:0]            rcnt_q, rcnt_d;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    stage_d   = stage_q;
    all_rel_d = all_rel_q;
    rcnt_d    = rcnt_q;
    case (state_q)
      ST_HOLD: begin
        stage_d   = '0;
        all_rel_d = 1'b0;
        gap_d     = '0;
        // A fault on the terminal count wins: counter just clears.
        if (!clean) begin
          hold_d = '0;
        end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          hold_d  = '0;
          stage_d = NUM_STAGES'(1);
          if (NUM_STAGES == 1) begin
            state_d   = ST_RUN;
            all_rel_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (!clean) begin
          state_d   = ST_HOLD;
          stage_d   = '0;
          all_rel_d = 1'b0;
          hold_d    = '0;
          gap_d     = '0;
          if (rcnt_q != 8'hff) rcnt_d = rcnt_q + 8'd1;
        end else if (state_q == ST_RELEASE) begin
          if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
            gap_d   = '0;
            stage_d = (stage_q << 1) | NUM_STAGES'(1);
            if (stage_d[NUM_STAGES-1]) begin
              state_d   = ST_RUN;
              all_rel_d = 1'b1;
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: begin
        state_d   = ST_HOLD;
        stage_d   = '0;
        all_rel_d = 1'b0;
        hold_d    = '0;
        gap_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_HOLD;
      hold_q    <= '0;
      gap_q     <= '0;
      stage_q   <= '0;
      all_rel_q <= 1'b0;
      rcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      stage_q   <= stage_d;
      all_rel_q <= all_rel_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign stage_reset_n = stage_q;
  assign all_released  = all_rel_q;
  assign state_o       = state_q;
  assign reset_count   = rcnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer; expectations follow RESET_SEQ_DEBOUNCE_EN.
module tb_reset_sequencer;

`ifdef RESET_SEQ_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_n;
  logic [1:0] pll_locked;
  logic [2:0] stage_reset_n;
  logic       all_released;
  logic [1:0] state_o;
  logic [7:0] reset_count;

  int total = 0;
  int bad   = 0;

  reset_sequencer #(
    .HOLD_CYCLES(10), .NUM_LOCKS(2), .NUM_STAGES(3),
    .STAGE_GAP(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_n         (btn_n),
    .pll_locked    (pll_locked),
    .stage_reset_n (stage_reset_n),
    .all_released  (all_released),
    .state_o       (state_o),
    .reset_count   (reset_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic al,
                         input logic [1:0] s, input logic [7:0] c);
    chk({tag, ".stage"}, 32'(stage_reset_n), 32'(st));
    chk({tag, ".all"},   32'(all_released),  32'(al));
    chk({tag, ".state"}, 32'(state_o),       32'(s));
    chk({tag, ".count"}, 32'(reset_count),   32'(c));
  endtask

  // Called just after the edge on which the last fault pin returned clean;
  // extra is the added filter latency of that pin's path.
  task automatic check_release(input string tag, input int extra, input int cnt);
    step(11 + extra);
    chk_out({tag, ".pre0"}, 3'b000, 1'b0, 2'd0, 8'(cnt));
    step(1);
    chk_out({tag, ".s0"},   3'b001, 1'b0, 2'd1, 8'(cnt));
    step(3);
    chk({tag, ".pre1"}, 32'(stage_reset_n), 32'h1);
    step(1);
    chk_out({tag, ".s1"},   3'b011, 1'b0, 2'd1, 8'(cnt));
    step(3);
    chk({tag, ".pre2"}, 32'(all_released), 32'h0);
    step(1);
    chk_out({tag, ".s2"},   3'b111, 1'b1, 2'd2, 8'(cnt));
  endtask

  initial begin
    reset_n    = 1'b0;
    btn_n      = 1'b1;
    pll_locked = 2'b11;
    step(3);
    chk_out("reset", 3'b000, 1'b0, 2'd0, 8'd0);

    // Power-up sequence.
    reset_n = 1'b1;
    check_release("pwrup", DB, 0);

    // Lock loss in RUN: fault on third edge.
    pll_locked[0] = 1'b0;
    step(2);
    chk("lockdrop.pre", 32'(stage_reset_n), 32'h7);
    step(1);
    chk_out("lockdrop", 3'b000, 1'b0, 2'd0, 8'd1);
    pll_locked[0] = 1'b1;
    check_release("relock", 0, 1);

`ifdef RESET_SEQ_DEBOUNCE_EN
    btn_n = 1'b0;
    step(3);
    btn_n = 1'b1;
    chk("glitch.a", 32'(stage_reset_n), 32'h7);
    step(12);
    chk_out("glitch.b", 3'b111, 1'b1, 2'd2, 8'd1);
    btn_n = 1'b0;
    step(10);
    chk("press.pre", 32'(stage_reset_n), 32'h7);
    step(1);
    chk_out("press", 3'b000, 1'b0, 2'd0, 8'd2);
    step(1);
    btn_n = 1'b1;
    check_release("btnrel", DB, 2);
`else
    btn_n = 1'b0;
    step(2);
    chk("glitch.pre", 32'(stage_reset_n), 32'h7);
    step(1);
    chk_out("glitch", 3'b000, 1'b0, 2'd0, 8'd2);
    btn_n = 1'b1;
    check_release("btnrel", DB, 2);
`endif

    // Repeated one-cycle lock pulses: counter must saturate, not wrap.
    for (int i = 0; i < 300; i++) begin
      pll_locked[0] = 1'b0;
      step(1);
      pll_locked[0] = 1'b1;
      step(2);
      chk("sat.cnt", 32'(reset_count), (3 + i > 255) ? 32'd255 : 32'(3 + i));
      step(10);
    end
    chk_out("sat.end", 3'b001, 1'b0, 2'd1, 8'd255);

    // Block reset mid-RELEASE clears everything on the next edge.
    reset_n = 1'b0;
    step(1);
    chk_out("midrst", 3'b000, 1'b0, 2'd0, 8'd0);
    step(1);
    reset_n = 1'b1;

    // Lock[1] drops so the fault lands on the terminal hold count.
    step(9 + DB);
    pll_locked[1] = 1'b0;
    step(3);
    chk_out("lk1.term", 3'b000, 1'b0, 2'd0, 8'd0);
    step(2);
    pll_locked[1] = 1'b1;
    step(11);
    chk_out("lk1.pre0", 3'b000, 1'b0, 2'd0, 8'd0);
    step(1);
    chk_out("lk1.s0", 3'b001, 1'b0, 2'd1, 8'd0);
    step(8);
    chk_out("lk1.run", 3'b111, 1'b1, 2'd2, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
